triangle_monitor: RTL and testbench

Receive-side checker for the triangle-wave sample stream produced by the team's triangle generator. It consumes one sample per enabled clock and tracks slope direction. It flags peaks, troughs and discontinuities, measures the period in samples, and asserts `locked` once the waveform is stable. It sits downstream of the generator, or of any block forwarding its samples, as a self-check and for bench-free bring-up on hardware.

---
 rtl/triangle_pkg.sv | 29 ++
 rtl/triangle_monitor.sv | 135 +++++++++++++
 tb/tb_triangle_monitor.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/triangle_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | triangle_pkg : shared types and step classifier for triangle IP   |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
package triangle_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SEED  = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STEP_UP   = 2'd0,
    STEP_DOWN = 2'd1,
    STEP_BAD  = 2'd2
  } step_t;

  // Operands are zero-extended to 32 bits so +/-1 never wraps for widths up to 31.
  function automatic step_t classify_step(input logic [31:0] prev, input logic [31:0] cur);
    if (cur == prev + 32'd1) return STEP_UP;
    if (prev == cur + 32'd1) return STEP_DOWN;
    return STEP_BAD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/triangle_monitor.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | triangle_monitor : slope/peak/trough/period checker for a         |
// | triangle sample stream, with lock indication.   rev 1.0           |
// +-------------------------------------------------------------------+
module triangle_monitor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N:0]   in,
  output logic         dir,
  output logic         peak,
  output logic         trough,
  output logic [N:0]   extreme,
  output logic [N+2:0] period,
  output logic         period_valid,
  output logic         error,
  output logic         locked
);
  import triangle_pkg::*;

  localparam logic [N+2:0] c_CNT_ONE = (N+3)'(1);

  state_t       r_state;
  state_t       w_state_nxt;
  step_t        w_step;
  logic [N:0]   r_prev;
  logic [N+2:0] r_cnt;
  logic [N+2:0] w_cnt_inc;
  logic         r_armed;
  logic         r_dir;
  logic         r_peak;
  logic         r_trough;
  logic         r_err;
  logic [N:0]   r_extreme;
  logic [N+2:0] r_period;
  logic         r_period_valid;
  logic         r_locked;
  logic         w_peak;
  logic         w_trough;
  logic         w_err;

  always_comb begin
    w_step      = classify_step(32'(r_prev), 32'(in));
    w_state_nxt = r_state;
    w_peak      = 1'b0;
    w_trough    = 1'b0;
    w_err       = 1'b0;
    w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + c_CNT_ONE;
    if (ena) begin
      case (r_state)
        EMPTY: w_state_nxt = SEED;
        SEED: begin
          case (w_step)
            STEP_UP:   w_state_nxt = UP;
            STEP_DOWN: w_state_nxt = DOWN;
            default:   w_err = 1'b1;
          endcase
        end
        UP: begin
          case (w_step)
            STEP_UP:   w_state_nxt = UP;
            STEP_DOWN: begin w_state_nxt = DOWN; w_peak = 1'b1; end
            default:   begin w_state_nxt = SEED; w_err = 1'b1; end
          endcase
        end
        DOWN: begin
          case (w_step)
            STEP_DOWN: w_state_nxt = DOWN;
            STEP_UP:   begin w_state_nxt = UP; w_trough = 1'b1; end
            default:   begin w_state_nxt = SEED; w_err = 1'b1; end
          endcase
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= EMPTY;
      r_prev         <= '0;
      r_cnt          <= '0;
      r_armed        <= 1'b0;
      r_dir          <= 1'b0;
      r_peak         <= 1'b0;
      r_trough       <= 1'b0;
      r_err          <= 1'b0;
      r_extreme      <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
    end else begin
      r_peak   <= w_peak;
      r_trough <= w_trough;
      r_err    <= w_err;
      if (ena) begin
        r_state <= w_state_nxt;
        r_prev  <= in;
        r_dir   <= (w_state_nxt == UP);
        if (r_state == UP || r_state == DOWN) r_cnt <= w_cnt_inc;
        if (w_peak) r_extreme <= r_prev;
        if (w_trough) begin
          r_extreme <= r_prev;
          r_cnt     <= c_CNT_ONE;
          r_armed   <= 1'b1;
          // Only a trough that closes a counted interval yields a measurement.
          if (r_armed) begin
            r_period       <= r_cnt;
            r_period_valid <= 1'b1;
            r_locked       <= r_period_valid && (r_cnt == r_period);
          end
        end
        if (w_err) begin
          r_locked       <= 1'b0;
          r_period_valid <= 1'b0;
          r_armed        <= 1'b0;
        end
      end
    end
  end

  assign dir          = r_dir;
  assign peak         = r_peak;
  assign trough       = r_trough;
  assign extreme      = r_extreme;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign error        = r_err;
  assign locked       = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_triangle_monitor.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_triangle_monitor : randomized, model-checked bench for         |
// | triangle_monitor.   rev 1.0                                       |
// +-------------------------------------------------------------------+
module tb_triangle_monitor;
  localparam int N       = 8;
  localparam int VMAX    = (1 << (N + 1)) - 1;
  localparam int CNT_MAX = (1 << (N + 3)) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b0;
  logic [N:0]   in_v = '0;
  logic         dir, peak, trough, period_valid, error, locked;
  logic [N:0]   extreme;
  logic [N+2:0] period;

  triangle_monitor #(.N(N)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in(in_v),
    .dir(dir), .peak(peak), .trough(trough), .extreme(extreme),
    .period(period), .period_valid(period_valid), .error(error), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int gap_pct = 0;
  bit chk_en = 0;

  // Behavioural model: slope as a signed integer, difference via plain arithmetic.
  bit m_have, m_armed;
  int m_prev, m_slope, m_cnt, m_d;
  int exp_peak, exp_trough, exp_err, exp_extreme, exp_period, exp_pv, exp_locked;

  always @(posedge clk) begin
    exp_peak = 0; exp_trough = 0; exp_err = 0;
    if (rst) begin
      m_have = 0; m_armed = 0; m_prev = 0; m_slope = 0; m_cnt = 0;
      exp_extreme = 0; exp_period = 0; exp_pv = 0; exp_locked = 0;
    end else if (ena) begin
      if (!m_have) begin
        m_have = 1; m_slope = 0;
      end else begin
        m_d = int'(in_v) - m_prev;
        if (m_d != 1 && m_d != -1) begin
          exp_err = 1; m_slope = 0; exp_locked = 0; exp_pv = 0; m_armed = 0;
        end else begin
          if (m_slope == -1 && m_d == 1) begin
            exp_trough = 1; exp_extreme = m_prev;
            if (m_armed) begin
              exp_locked = (exp_pv == 1 && m_cnt == exp_period) ? 1 : 0;
              exp_period = m_cnt; exp_pv = 1;
            end
            m_armed = 1; m_cnt = 1;
          end else if (m_slope != 0) begin
            m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
          end
          if (m_slope == 1 && m_d == -1) begin
            exp_peak = 1; exp_extreme = m_prev;
          end
          m_slope = m_d;
        end
      end
      m_prev = int'(in_v);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("peak", 32'(peak), exp_peak);
      chk("trough", 32'(trough), exp_trough);
      chk("error", 32'(error), exp_err);
      chk("extreme", 32'(extreme), exp_extreme);
      chk("period", 32'(period), exp_period);
      chk("period_valid", 32'(period_valid), exp_pv);
      chk("locked", 32'(locked), exp_locked);
      if (m_slope != 0) chk("dir", 32'(dir), (m_slope == 1) ? 1 : 0);
    end
  end

  task automatic send(input int v);
    while ($urandom_range(99) < gap_pct) begin
      @(negedge clk); rst = 1'b0; ena = 1'b0; in_v = (N+1)'($urandom);
    end
    @(negedge clk); rst = 1'b0; ena = 1'b1; in_v = (N+1)'(v);
  endtask

  task automatic do_reset(input int v);
    @(negedge clk); rst = 1'b1; ena = 1'b1; in_v = (N+1)'(v);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic up(input int a, input int b);
    for (int v = a; v <= b; v++) send(v);
  endtask

  task automatic down(input int a, input int b);
    for (int v = a; v >= b; v--) send(v);
  endtask

  task automatic period_tail();
    up(2, 255); down(254, 0); send(1);
  endtask

  int rv, rdir;

  initial begin
    do_reset(0); settle();
    chk_en = 1;
    chk("rst_extreme", 32'(extreme), 0);
    chk("rst_locked", 32'(locked), 0);

    // Ideal stream
    up(0, 255); send(254); settle();
    chk("ideal_peak", 32'(peak), 1);
    chk("ideal_peak_ext", 32'(extreme), 255);
    down(253, 0); send(1); settle();
    chk("ideal_trough", 32'(trough), 1);
    chk("ideal_trough_ext", 32'(extreme), 0);
    chk("ideal_pv_first", 32'(period_valid), 0);
    period_tail(); settle();
    chk("ideal_period", 32'(period), 510);
    chk("ideal_pv", 32'(period_valid), 1);
    chk("ideal_lock_early", 32'(locked), 0);
    period_tail(); settle();
    chk("ideal_locked", 32'(locked), 1);

    // Glitch: 100 substituted for 101
    up(2, 100); send(100); settle();
    chk("glitch_err", 32'(error), 1);
    chk("glitch_locked", 32'(locked), 0);
    chk("glitch_pv", 32'(period_valid), 0);
    up(102, 255); down(254, 0); send(1);
    period_tail(); settle();
    chk("glitch_relock_early", 32'(locked), 0);
    period_tail(); settle();
    chk("glitch_relocked", 32'(locked), 1);

    // Wrap
    do_reset(0);
    send(510); send(511); send(0); settle();
    chk("wrap_err", 32'(error), 1);
    send(1); settle();
    chk("wrap_no_err", 32'(error), 0);
    chk("wrap_no_peak", 32'(peak), 0);
    chk("wrap_dir", 32'(dir), 1);

    // Short triangle, then mid-ramp reset
    do_reset(0);
    send(5); send(6); send(5); send(6); send(5); send(6); send(5); send(6); settle();
    chk("short_period", 32'(period), 2);
    chk("short_locked", 32'(locked), 1);
    chk("short_extreme", 32'(extreme), 5);
    up(7, 36); do_reset(37); settle();
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_period", 32'(period), 0);
    chk("midrst_extreme", 32'(extreme), 0);
    send(38); settle();
    chk("midrst_s1", 32'(peak | trough | error), 0);
    send(39); settle();
    chk("midrst_s2", 32'(peak | trough | error), 0);

    // Ideal ramp with ena gaps
    do_reset(0);
    gap_pct = 35;
    up(0, 255); down(254, 0); send(1);
    period_tail(); period_tail(); settle();
    chk("gap_period", 32'(period), 510);
    chk("gap_locked", 32'(locked), 1);

    // Random walk with reversals, jumps and plateaus
    gap_pct = 20;
    rv = int'($urandom_range(VMAX)); rdir = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(999));
      if (r < 15) rv = int'($urandom_range(VMAX));
      else if (r < 25) rv = rv;
      else begin
        if (r < 120 || rv + rdir < 0 || rv + rdir > VMAX) rdir = -rdir;
        rv = rv + rdir;
      end
      if (r >= 990) do_reset(rv);
      else send(rv);
    end
    settle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
